// File: rtl/alu_pkg.sv
// Package: alu_pkg
// Opcode map shared by the ALU pipeline, the controller and the decoder.
// Contents:
//   OP_HLT..OP_JMP  3-bit opcode encodings
//   writes_carry()  1 for the only opcode that updates the carry flag
package alu_pkg;

  localparam int OPCODE_W = 3;

  localparam logic [OPCODE_W-1:0] OP_HLT = 3'b000;
  localparam logic [OPCODE_W-1:0] OP_SKZ = 3'b001;
  localparam logic [OPCODE_W-1:0] OP_ADD = 3'b010;
  localparam logic [OPCODE_W-1:0] OP_AND = 3'b011;
  localparam logic [OPCODE_W-1:0] OP_XOR = 3'b100;
  localparam logic [OPCODE_W-1:0] OP_LDA = 3'b101;
  localparam logic [OPCODE_W-1:0] OP_STO = 3'b110;
  localparam logic [OPCODE_W-1:0] OP_JMP = 3'b111;

  function automatic logic writes_carry(input logic [OPCODE_W-1:0] op);
    return (op == OP_ADD);
  endfunction

endpackage

// File: rtl/alu_core.sv
// Module: alu_core
// Combinational ALU datapath.
// Ports:
//   a       in   WIDTH  accumulator operand
//   b       in   WIDTH  memory/data operand
//   cin     in   1      current carry flag
//   opcode  in   3      operation select
//   y       out  WIDTH  result
//   cout    out  1      carry flag after this operation (cin unless ADD)
//   a_zero  out  1      a == 0
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter bit ADC_EN = 1'b0
) (
  input  logic [WIDTH-1:0]    a,
  input  logic [WIDTH-1:0]    b,
  input  logic                cin,
  input  logic [OPCODE_W-1:0] opcode,
  output logic [WIDTH-1:0]    y,
  output logic                cout,
  output logic                a_zero
);

  logic [WIDTH:0] sum;
  logic           add_cin;

  // The stored flag only feeds the adder when add-with-carry is enabled.
  assign add_cin = ADC_EN ? cin : 1'b0;
  assign sum     = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, add_cin};
  assign a_zero  = (a == '0);

  always_comb begin
    y    = a;
    cout = cin;
    case (opcode)
      OP_ADD: begin
        y    = sum[WIDTH-1:0];
        cout = sum[WIDTH];
      end
      OP_AND:  y = a & b;
      OP_XOR:  y = a ^ b;
      OP_LDA:  y = b;
      default: y = a;  // HLT, SKZ, STO, JMP pass the accumulator through
    endcase
  end

endmodule

// File: rtl/alu_pipe.sv
// Module: alu_pipe
// Two-stage pipelined ALU with valid/ready flow control and a registered
// carry flag. Stage 1 captures operands; stage 2 computes and holds the
// result until downstream takes it.
// Ports:
//   clk         in   1      rising-edge clock
//   rst         in   1      synchronous reset, active-high
//   in_valid    in   1      operand beat present
//   in_ready    out  1      stage 1 can accept a beat this cycle
//   in_a        in   WIDTH  accumulator operand
//   in_b        in   WIDTH  memory/data operand
//   opcode      in   3      operation select
//   out_valid   out  1      result beat present
//   out_ready   in   1      downstream accepts the result this cycle
//   alu_out     out  WIDTH  result
//   a_is_zero   out  1      in_a of this beat was 0
//   carry_out   out  1      carry flag after this beat
//   opcode_out  out  3      opcode of this beat
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter bit ADC_EN = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH-1:0]    in_a,
  input  logic [WIDTH-1:0]    in_b,
  input  logic [OPCODE_W-1:0] opcode,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    alu_out,
  output logic                a_is_zero,
  output logic                carry_out,
  output logic [OPCODE_W-1:0] opcode_out
);

  logic                s1_valid;
  logic [WIDTH-1:0]    s1_a;
  logic [WIDTH-1:0]    s1_b;
  logic [OPCODE_W-1:0] s1_op;

  // The carry flag is exactly the carry_out register: it is only written
  // when a beat moves into stage 2, which is also when carry_out loads.
  logic                carry_flag;

  logic                advance;
  logic                accept;
  logic [WIDTH-1:0]    core_y;
  logic                core_cout;
  logic                core_a_zero;

  assign advance   = !out_valid || out_ready;
  assign in_ready  = !s1_valid || advance;
  assign accept    = in_valid && in_ready;
  assign carry_out = carry_flag;

  alu_core #(
    .WIDTH  (WIDTH),
    .ADC_EN (ADC_EN)
  ) u_core (
    .a      (s1_a),
    .b      (s1_b),
    .cin    (carry_flag),
    .opcode (s1_op),
    .y      (core_y),
    .cout   (core_cout),
    .a_zero (core_a_zero)
  );

  // Stage 1. When in_ready is high, whatever S1 held has moved on (or S1
  // was empty), so s1_valid simply follows in_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= OP_HLT;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (accept) begin
        s1_a  <= in_a;
        s1_b  <= in_b;
        s1_op <= opcode;
      end
    end
  end

  // Stage 2. Data registers only load with a real beat so the outputs stay
  // stable across bubbles; carry chains back-to-back because the core reads
  // the flag that the previous beat left in this register.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      alu_out    <= '0;
      a_is_zero  <= 1'b0;
      carry_flag <= 1'b0;
      opcode_out <= OP_HLT;
    end else if (advance) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        alu_out    <= core_y;
        a_is_zero  <= core_a_zero;
        opcode_out <= s1_op;
        if (writes_carry(s1_op)) begin
          carry_flag <= core_cout;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
module tb_alu_pipe;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_a, in_b;
  logic [2:0] opcode;
  logic       out_ready;

  logic       in_ready0, out_valid0, z0, c0;
  logic [7:0] y0;
  logic [2:0] op0;
  logic       in_ready1, out_valid1, z1, c1;
  logic [7:0] y1;
  logic [2:0] op1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(8), .ADC_EN(1'b0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .in_a(in_a), .in_b(in_b), .opcode(opcode), .out_valid(out_valid0),
    .out_ready(out_ready), .alu_out(y0), .a_is_zero(z0), .carry_out(c0),
    .opcode_out(op0)
  );

  alu_pipe #(.WIDTH(8), .ADC_EN(1'b1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .in_a(in_a), .in_b(in_b), .opcode(opcode), .out_valid(out_valid1),
    .out_ready(out_ready), .alu_out(y1), .a_is_zero(z1), .carry_out(c1),
    .opcode_out(op1)
  );

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] y;
    logic       z;
    logic       c;
  } vec_t;

  vec_t vecs[11];
  logic [7:0] exp_s[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drive(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    in_valid = 1'b1;
    opcode = op;
    in_a = a;
    in_b = b;
  endtask

  initial begin
    int tx, rx;
    bit seen_block;

    vecs[0]  = '{OP_ADD, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0};
    vecs[1]  = '{OP_ADD, 8'hFF, 8'h01, 8'h00, 1'b0, 1'b1};
    vecs[2]  = '{OP_AND, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b1};
    vecs[3]  = '{OP_LDA, 8'h00, 8'hA5, 8'hA5, 1'b1, 1'b1};
    vecs[4]  = '{OP_XOR, 8'h0F, 8'hFF, 8'hF0, 1'b0, 1'b1};
    vecs[5]  = '{OP_SKZ, 8'h07, 8'h55, 8'h07, 1'b0, 1'b1};
    vecs[6]  = '{OP_HLT, 8'h00, 8'h11, 8'h00, 1'b1, 1'b1};
    vecs[7]  = '{OP_STO, 8'h9C, 8'h11, 8'h9C, 1'b0, 1'b1};
    vecs[8]  = '{OP_JMP, 8'h3E, 8'hFF, 8'h3E, 1'b0, 1'b1};
    vecs[9]  = '{OP_ADD, 8'h80, 8'h7F, 8'hFF, 1'b0, 1'b0};
    vecs[10] = '{OP_ADD, 8'h80, 8'h80, 8'h00, 1'b0, 1'b1};

    exp_s[0] = 8'h30;
    exp_s[1] = 8'hFF;
    exp_s[2] = 8'h10;
    exp_s[3] = 8'h0F;

    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    opcode = OP_HLT;
    out_ready = 1'b1;
    @(negedge clk);
    do_reset();

    // reset state
    check("rst_out_valid", out_valid0, 0);
    check("rst_in_ready", in_ready0, 1);
    check("rst_alu_out", y0, 0);
    check("rst_a_is_zero", z0, 0);
    check("rst_carry", c0, 0);
    check("rst_opcode_out", op0, 0);

    // single beats, ADC_EN=0 instance, carry flag carried across vectors
    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].op, vecs[i].a, vecs[i].b);
      @(negedge clk);
      in_valid = 1'b0;
      check("vec_early_valid", out_valid0, 0);
      @(negedge clk);
      check("vec_out_valid", out_valid0, 1);
      check("vec_alu_out", y0, vecs[i].y);
      check("vec_a_is_zero", z0, vecs[i].z);
      check("vec_carry", c0, vecs[i].c);
      check("vec_opcode_out", op0, vecs[i].op);
    end
    @(negedge clk);
    check("bubble_valid", out_valid0, 0);
    check("bubble_hold", y0, 8'h00);

    // back-to-back ADD chain, both carry modes
    do_reset();
    drive(OP_ADD, 8'hFF, 8'h01);
    @(negedge clk);
    drive(OP_ADD, 8'h01, 8'h01);
    @(negedge clk);
    in_valid = 1'b0;
    check("chain1_adc0", y0, 8'h00);
    check("chain1_adc1", y1, 8'h00);
    check("chain1_c1", c1, 1);
    @(negedge clk);
    check("chain2_valid", out_valid1, 1);
    check("chain2_adc0", y0, 8'h02);
    check("chain2_adc1", y1, 8'h03);
    check("chain2_c1", c1, 0);
    @(negedge clk);

    // stream 4 beats with downstream stalled for the first 4 cycles
    tx = 0;
    rx = 0;
    seen_block = 1'b0;
    for (int cyc = 0; cyc < 40 && rx < 4; cyc++) begin
      out_ready = (cyc >= 4);
      #1;
      if (out_valid0) begin
        check("stream_data", y0, exp_s[rx]);
        if (out_ready) rx++;
      end
      if (tx < 4) begin
        case (tx)
          0: drive(OP_ADD, 8'h10, 8'h20);
          1: drive(OP_XOR, 8'hAA, 8'h55);
          2: drive(OP_ADD, 8'hF0, 8'h20);
          default: drive(OP_AND, 8'hFF, 8'h0F);
        endcase
        if (!in_ready0 && !seen_block) begin
          seen_block = 1'b1;
          check("stall_accepts", tx, 2);
        end
        if (in_ready0) tx++;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("stream_blocked", seen_block, 1);
    check("stream_count", rx, 4);
    check("stream_carry", c0, 1);
    @(negedge clk);
    check("no_dup", out_valid0, 0);

    // reset while stalled with carry set
    out_ready = 1'b0;
    drive(OP_ADD, 8'hFF, 8'h01);
    @(negedge clk);
    drive(OP_AND, 8'h00, 8'h00);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_valid", out_valid1, 1);
    check("pre_rst_carry", c1, 1);
    check("pre_rst_in_ready", in_ready1, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("post_rst_valid", out_valid1, 0);
    check("post_rst_carry", c1, 0);
    check("post_rst_in_ready", in_ready1, 1);
    check("post_rst_alu_out", y1, 0);
    out_ready = 1'b1;
    drive(OP_ADD, 8'h01, 8'h01);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("post_rst_add_valid", out_valid1, 1);
    check("post_rst_add", y1, 8'h02);
    @(negedge clk);
    check("post_rst_drained", out_valid1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
